div_job_sequencer: RTL

- Request sequencer that sits directly upstream of the sequential divider controller/datapath.
- Buffers divide jobs (dividend, divisor) in a small FIFO and issues them to the divider one at a time with a one-cycle start pulse.
- Captures the divider's completion outcome (valid/ovf/dvz) and returns quotient plus status over a valid/ready response port.
- Watchdog pulses a divider-local clear if a job never completes.

---
 rtl/div_job_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/div_job_sequencer.sv
// Job sequencer in front of the sequential divider. It queues (dividend, divisor) jobs, issues them
// one at a time, and returns the quotient with a completion status over a valid/ready response port.
module div_job_sequencer #(
    parameter int WIDTH   = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   sclr,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH-1:0]       req_a,
    input  logic [WIDTH-1:0]       req_b,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    input  logic                   div_busy,
    input  logic                   div_valid,
    input  logic                   div_ovf,
    input  logic                   div_dvz,
    input  logic [WIDTH-1:0]       div_q,
    output logic                   div_sclr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_q,
    output logic [1:0]             rsp_status,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_OVF     = 2'b01;
    localparam logic [1:0] STATUS_DVZ     = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic             push;
    logic             pop;
    logic             done_any;

    assign req_ready = (count < FULL_COUNT);
    assign push      = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign pop       = rsp_valid && rsp_ready;
    assign div_start = (state == ST_ISSUE);
    assign div_sclr  = (state == ST_RECOVER);
    assign div_a     = mem_a[rd_ptr];
    assign div_b     = mem_b[rd_ptr];
    assign pending   = count;
    assign done_any  = div_dvz || div_ovf || div_valid;

    // NOTE: the storage array has no reset; emptiness is carried entirely by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr] <= req_a;
            mem_b[wr_ptr] <= req_b;
        end
    end

    // The head entry is only released on the response handshake, so div_a/div_b stay put while in flight.
    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaulting the next state before the case keeps this block free of inferred latches.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if ((count != '0) && !div_busy) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (done_any) begin
                    state_next = ST_RESP;
                end else if (timer == TIMER_LAST) begin
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ((count > ONE_COUNT) && !div_busy) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Completion pulses are only looked at in RUN; dvz outranks ovf, which outranks valid.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state      <= ST_IDLE;
            timer      <= '0;
            rsp_q      <= '0;
            rsp_status <= STATUS_OK;
        end else begin
            state <= state_next;
            case (state)
                ST_ISSUE: begin
                    timer <= '0;
                end
                ST_RUN: begin
                    if (div_dvz) begin
                        rsp_q      <= '0;
                        rsp_status <= STATUS_DVZ;
                    end else if (div_ovf) begin
                        rsp_q      <= '0;
                        rsp_status <= STATUS_OVF;
                    end else if (div_valid) begin
                        rsp_q      <= div_q;
                        rsp_status <= STATUS_OK;
                    end else if (timer == TIMER_LAST) begin
                        rsp_q      <= '0;
                        rsp_status <= STATUS_TIMEOUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer <= timer;
                end
            endcase
        end
    end

endmodule
